// File: rtl/note_voice.sv
// note_voice: one synth voice; plays a triangle-wave note per load/done handshake.
// Define NOTE_VOICE_RELEASE_EN to halve the amplitude during the final beat.
module note_voice #(
    parameter int PHASE_W = 22,
    parameter int DUR_W   = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [PHASE_W-1:0] step,
    input  logic [DUR_W-1:0]   duration,
    input  logic               beat,
    input  logic               generate_next_sample,
    output logic               done,
    output logic [15:0]        sample_out,
    output logic               sample_valid
);
    typedef enum logic {IDLE, PLAYING} state_t;
    state_t             r_state, w_next;
    logic [PHASE_W-1:0] r_phase, r_step, w_phase_nxt;
    logic [DUR_W-1:0]   r_beats;
    logic [15:0]        w_p, w_wave, w_shaped, w_sample;
    logic [14:0]        w_t;
    logic               w_accept, w_expire, w_last;
    always_comb begin
        w_last   = r_beats == DUR_W'(1);
        w_accept = load && r_state == IDLE && duration != '0;
        w_expire = r_state == PLAYING && beat && w_last;
        w_next   = w_accept ? PLAYING : (w_expire ? IDLE : r_state);
    end
    // Waveform is taken from the post-increment phase so the first sample already moves.
    always_comb begin
        w_phase_nxt = r_phase + r_step;
        w_p         = w_phase_nxt[PHASE_W-1 -: 16];
        w_t         = w_p[15] ? ~w_p[14:0] : w_p[14:0];
        w_wave      = {w_t, 1'b0} - 16'h8000;
`ifdef NOTE_VOICE_RELEASE_EN
        w_shaped    = w_last ? {w_wave[15], w_wave[15:1]} : w_wave;
`else
        w_shaped    = w_wave;
`endif
        w_sample    = (r_state == PLAYING && !w_expire && r_step != '0) ? w_shaped : '0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_phase      <= '0;
            r_step       <= '0;
            r_beats      <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            r_state      <= w_next;
            sample_valid <= generate_next_sample;
            if (w_accept) begin
                r_step  <= step;
                r_beats <= duration;
                r_phase <= '0;
            end else if (r_state == PLAYING) begin
                if (w_expire)
                    r_beats <= '0;
                else if (beat)
                    r_beats <= r_beats - DUR_W'(1);
                if (generate_next_sample && !w_expire)
                    r_phase <= w_phase_nxt;
            end
            if (generate_next_sample)
                sample_out <= w_sample;
            else if (w_expire)
                sample_out <= '0;
        end
    end
    assign done = r_state == IDLE;
endmodule
